// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with a registered read port and full/empthy flags.
// Storage is a plain register array named memory so it can be probed hierarchically.
module sync_fifo #(
  parameter int unsigned width     = 4,
  parameter int unsigned height    = 8,
  parameter int unsigned ptr_width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] data_in,
  input  logic             write,
  input  logic             read,
  output logic [width-1:0] data_out,
  output logic             full,
  output logic             empthy
);

  localparam int unsigned CntW = ptr_width + 1;

  logic [width-1:0]     memory [height];

  logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [width-1:0]     data_out_q, data_out_d;

  logic                 wr_acc;
  logic                 rd_acc;

  // Flags come straight from the registered count, so they never glitch.
  assign full     = (count_q == CntW'(height));
  assign empthy   = (count_q == '0);
  assign data_out = data_out_q;

  // Accept decisions; a write into a full FIFO is allowed only alongside a read.
  always_comb begin
    rd_acc = read && !empthy;
    wr_acc = write && (!full || rd_acc);
  end

  // Next-state for pointers, occupancy and the registered read data.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_width'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ptr_width'(1);
      data_out_d = memory[rd_ptr_q];
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CntW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array: cleared on reset, written at the write pointer on an accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(height); i++) begin
        memory[i] <= '0;
      end
    end else if (wr_acc) begin
      memory[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue scoreboard of the expected FIFO contents.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic       write;
  logic       read;
  logic [3:0] data_out;
  logic       full;
  logic       empthy;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb [$];
  logic [3:0] exp_mem [8];
  logic [3:0] exp_dout;
  int         mwp;

  sync_fifo #(
    .width    (4),
    .height   (8),
    .ptr_width(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .write   (write),
    .read    (read),
    .data_out(data_out),
    .full    (full),
    .empthy  (empthy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_dout = '0;
    mwp = 0;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".data_out"}, data_out, exp_dout);
    chk({tag, ".full"}, full, (sb.size() == 8));
    chk({tag, ".empthy"}, empthy, (sb.size() == 0));
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.mem%0d", tag, i), dut.memory[i], exp_mem[i]);
    end
  endtask

  // Called at a falling edge: drive, update the model, clock once, check at the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [3:0] d, input string tag);
    logic ra;
    logic wa;
    write   = w;
    read    = r;
    data_in = d;
    ra = r && (sb.size() != 0);
    wa = w && ((sb.size() < 8) || ra);
    if (ra) exp_dout = sb.pop_front();
    if (wa) begin
      sb.push_back(d);
      exp_mem[mwp] = d;
      mwp = (mwp + 1) % 8;
    end
    @(posedge clk);
    @(negedge clk);
    chk_flags(tag);
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; data_in = '0;
    model_reset();

    // Reset takes effect without a clock edge.
    #3 rst = 1'b0;
    #1;
    chk_flags("reset");
    chk_mem("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 4'(i), $sformatf("fill%0d", i));
    chk_mem("fill");

    // Overflow attempts are ignored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'd9, "overflow");
    chk_mem("overflow");

    // Drain in order, then underflow holds last word.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 4'd0, $sformatf("drain%0d", i));
      chk($sformatf("drain_order%0d", i), data_out, i);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 4'd0, "underflow");
    chk("underflow_hold", data_out, 8);

    // Wrap-around: write 5, read 3, write 6 -> full.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'(10 + i), "wrap_w1");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd0, "wrap_r");
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, 4'(i), "wrap_w2");
    chk("wrap_full", full, 1);
    chk_mem("wrap");

    // Read+write while full: oldest out, stays full.
    cycle(1'b1, 1'b1, 4'd15, "rw_full");
    chk("rw_full_oldest", data_out, 13);
    chk("rw_full_stay", full, 1);

    // Read+write mid-level keeps occupancy.
    cycle(1'b0, 1'b1, 4'd0, "mid_r1");
    cycle(1'b0, 1'b1, 4'd0, "mid_r2");
    cycle(1'b1, 1'b1, 4'd7, "mid_rw");

    // Mid-operation reset with a write pending; inputs ignored while low.
    write = 1'b1; data_in = 4'd5;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk_flags("rst_mid");
    chk_mem("rst_mid");
    @(posedge clk);
    #1;
    chk_flags("rst_hold");
    @(negedge clk);
    rst = 1'b1; write = 1'b0;

    // Four writes, then pulse reset again.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 4'(i + 2), "refill");
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk_flags("rst_fill");
    chk_mem("rst_fill");
    @(negedge clk);
    rst = 1'b1;

    // Read+write on empty: only the write happens, landing in memory[0].
    cycle(1'b1, 1'b1, 4'd3, "rw_empty");
    chk("rw_empty_mem0", dut.memory[0], 3);
    cycle(1'b0, 1'b1, 4'd0, "rw_empty_rd");
    chk("rw_empty_dout", data_out, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock synchronous FIFO buffering `width`-bit words, `height` entries deep. Writes and reads complete on the rising clock edge, and `full`/`empthy` flags provide backpressure. It sits between a producer and a consumer in the same clock domain. Storage is a register array named `memory` so that benches can probe it hierarchically.

## Interface
- `width`, default 4: data word width in bits.
- `height`, default 8: FIFO depth in entries; must equal 2^`ptr_width`.
- `ptr_width`, default 3: read/write pointer width.

- `clk`  input  1: the single clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `data_in`  input  `width`: write data.
- `write`  input  1: write request, sampled on `clk` rising edge.
- `read`  input  1: read request, sampled on `clk` rising edge.
- `data_out`  output  `width`: registered read data.
- `full`  output  1: high when the FIFO holds `height` entries.
- `empthy`  output  1: high when the FIFO holds 0 entries. The port name keeps this spelling.

## Operation
- Internal state:
  - `memory[0..height-1]`, each `width` bits.
  - `wr_ptr` and `rd_ptr`, each `ptr_width` bits.
  - `count`, `ptr_width+1` bits, range 0..`height`.
- Write accepted when `write`=1 and (`full`=0, or `read` is accepted in the same cycle):
  - `memory[wr_ptr]` <= `data_in`.
  - `wr_ptr` increments modulo `height`.
- Read accepted when `read`=1 and `empthy`=0:
  - `data_out` <= `memory[rd_ptr]`.
  - `rd_ptr` increments modulo `height`.
- `count` changes:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged when both are accepted or neither is.
- Flags: `full` = (`count`==`height`), `empthy` = (`count`==0). Both derive from registered `count`, so they are glitch-free.
- Boundary cases:
  - Write while full without a read: ignored. Memory, pointers and count are unchanged, and no error is flagged.
  - Read while empty: ignored, and `data_out` holds its previous value. This applies even if `write` is also high; only the write occurs.
  - Read and write together while full: both accepted, the oldest word is output, and the FIFO stays full.
  - Read and write together, neither full nor empty: both accepted, count unchanged.
  - Pointer wrap: `height-1` → 0 naturally via `ptr_width`-bit arithmetic.
- `data_out` holds its value when no read is accepted.

## Timing
- Reset (`rst`=0, asynchronous, takes effect immediately without a clock edge):
  - `wr_ptr`=`rd_ptr`=0, `count`=0.
  - `data_out`=0.
  - All `memory` entries = 0.
  - `empthy`=1, `full`=0.
  - All inputs are ignored while `rst`=0.
- Reset release is synchronous-safe: the first rising edge with `rst`=1 can accept a write.
- Reset asserted mid-operation discards all contents. Pending read/write in that cycle have no effect.
- Write latency:
  - A word written at edge N is readable by a read request sampled at edge N+1.
  - `empthy` falls right after edge N.
- Read latency: `data_out` updates right after the edge at which the read is accepted (one-cycle registered read, no first-word fall-through).
- Flags update right after the edge that changes `count`.

## Test plan
- **Reset:** assert `rst`=0 mid-cycle without a clock → immediately `empthy`=1, `full`=0, `data_out`=0, `memory[0..7]`=0.
- **Fill:** `write`=1 for 8 edges with `data_in`=1,2,…,8 (defaults) → `memory[0..7]`=1..8, `full`=1 after the 8th edge, `empthy`=0 after the 1st.
- **Overflow:** with the FIFO full, write `data_in`=9 for several edges → memory unchanged, `full` stays 1.
- **Drain and underflow:**
  - `read`=1 for 8 edges → `data_out`=1,2,…,8 in order, `empthy`=1 after the 8th, `full`=0 after the 1st.
  - Further reads → `data_out` holds 8.
- **Wrap-around and simultaneous access:**
  - Write 5 words, read 3, write 6 more → `wr_ptr` wraps, `full`=1.
  - Assert read+write together while full → output = oldest word, `full` stays 1, `count` stays 8.
- **Reset mid-fill:** after 4 writes, pulse `rst`=0 → `empthy`=1, `data_out`=0, memory cleared. The next write after release lands in `memory[0]`.
